// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// requester indices and the owner debug encoding.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam int REQ_CPU = 0;
  localparam int REQ_LDR = 1;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_R0   = 2'b01;
  localparam logic [1:0] OWNER_R1   = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin select: a lone request wins outright, a tie goes to
// the requester that was not served last.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    gnt[REQ_CPU] = req[REQ_CPU] & (~req[REQ_LDR] | last_served);
    gnt[REQ_LDR] = req[REQ_LDR] & (~req[REQ_CPU] | ~last_served);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the cpu core (r0) and the loader/debug
// port (r1): round-robin with locked ownership and a bounded hold time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic                  r0_lock,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_lock,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output logic [1:0]            owner
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  arb_state_t        state;
  logic              last_served;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        req_vec;
  logic [1:0]        rr_gnt;
  logic [1:0]        gnt;
  logic              hold_expired;

  assign req_vec = {r1_req, r0_req};

  rr_pick2 u_pick (
    .req        (req_vec),
    .last_served(last_served),
    .gnt        (rr_gnt)
  );

  // Grant is combinational from registered state; forced low while in reset.
  always_comb begin
    gnt = '0;
    case (state)
      ST_IDLE: gnt = rr_gnt;
      ST_OWN0: gnt[REQ_CPU] = r0_req;
      ST_OWN1: gnt[REQ_LDR] = r1_req;
      default: gnt = '0;
    endcase
    if (rst) gnt = '0;
  end

  assign r0_gnt = gnt[REQ_CPU];
  assign r1_gnt = gnt[REQ_LDR];

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (gnt[REQ_CPU]) begin
      mem_we   = r0_we;
      mem_addr = r0_addr;
      mem_data = r0_wdata;
    end else if (gnt[REQ_LDR]) begin
      mem_we   = r1_we;
      mem_addr = r1_addr;
      mem_data = r1_wdata;
    end
  end

  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= OWNER_NONE;
      last_served <= 1'b1;
      hold_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt[REQ_CPU]) begin
            last_served <= 1'(REQ_CPU);
            if (r0_lock) begin
              state    <= ST_OWN0;
              owner    <= OWNER_R0;
              hold_cnt <= HOLD_W'(1);
            end
          end else if (gnt[REQ_LDR]) begin
            last_served <= 1'(REQ_LDR);
            if (r1_lock) begin
              state    <= ST_OWN1;
              owner    <= OWNER_R1;
              hold_cnt <= HOLD_W'(1);
            end
          end
        end
        ST_OWN0: begin
          if (!r0_req || !r0_lock) begin
            state    <= ST_IDLE;
            owner    <= OWNER_NONE;
            hold_cnt <= '0;
          end else if (hold_expired && r1_req) begin
            // Release to the waiting side; it wins the following tie.
            state       <= ST_IDLE;
            owner       <= OWNER_NONE;
            hold_cnt    <= '0;
            last_served <= 1'(REQ_CPU);
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_OWN1: begin
          if (!r1_req || !r1_lock) begin
            state    <= ST_IDLE;
            owner    <= OWNER_NONE;
            hold_cnt <= '0;
          end else if (hold_expired && r0_req) begin
            state       <= ST_IDLE;
            owner       <= OWNER_NONE;
            hold_cnt    <= '0;
            last_served <= 1'(REQ_LDR);
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          owner    <= OWNER_NONE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      r0_rvalid <= gnt[REQ_CPU] & ~r0_we;
      r1_rvalid <= gnt[REQ_LDR] & ~r1_we;
    end
  end

  assign r0_rdata = mem_in;
  assign r1_rdata = mem_in;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (MAX_HOLD 8/3/0) share
// stimulus; the MAX_HOLD=8 instance drives a small behavioural memory.
module tb_mem_port_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          r0_req, r0_lock, r0_we, r1_req, r1_lock, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic [DW-1:0] mem_in;

  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we;
  logic [DW-1:0] r0_rdata, r1_rdata, mem_data;
  logic [AW-1:0] mem_addr;
  logic [1:0]    owner;

  logic          d3_r0_gnt, d3_r1_gnt, d3_r0_rvalid, d3_r1_rvalid, d3_mem_we;
  logic [DW-1:0] d3_r0_rdata, d3_r1_rdata, d3_mem_data;
  logic [AW-1:0] d3_mem_addr;
  logic [1:0]    d3_owner;

  logic          d0_r0_gnt, d0_r1_gnt, d0_r0_rvalid, d0_r1_rvalid, d0_mem_we;
  logic [DW-1:0] d0_r0_rdata, d0_r1_rdata, d0_mem_data;
  logic [AW-1:0] d0_mem_addr;
  logic [1:0]    d0_owner;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(8)) u_dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_in(mem_in), .owner(owner)
  );

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(d3_r0_gnt), .r0_rvalid(d3_r0_rvalid), .r0_rdata(d3_r0_rdata),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(d3_r1_gnt), .r1_rvalid(d3_r1_rvalid), .r1_rdata(d3_r1_rdata),
    .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_data(d3_mem_data), .mem_in(mem_in),
    .owner(d3_owner)
  );

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(d0_r0_gnt), .r0_rvalid(d0_r0_rvalid), .r0_rdata(d0_r0_rdata),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(d0_r1_gnt), .r1_rvalid(d0_r1_rvalid), .r1_rdata(d0_r1_rdata),
    .mem_we(d0_mem_we), .mem_addr(d0_mem_addr), .mem_data(d0_mem_data), .mem_in(mem_in),
    .owner(d0_owner)
  );

  // Behavioural memory: unwritten words read as 16'h1000 + address.
  logic [DW-1:0] mem [64];
  logic          wr  [64];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) wr[i] <= 1'b0;
      mem_in <= '0;
    end else begin
      if (mem_we) begin
        mem[mem_addr] <= mem_data;
        wr[mem_addr]  <= 1'b1;
      end
      mem_in <= wr[mem_addr] ? mem[mem_addr] : (16'h1000 + 16'(mem_addr));
    end
  end

  task automatic clear_inputs();
    r0_req = 0; r0_lock = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_lock = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we} !== 5'b0 || mem_addr !== '0 || owner !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: gnt=%b%b rvalid=%b%b we=%b addr=%0h owner=%b, required all 0",
               r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we, mem_addr, owner);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // r0 locked read stream plus r1 waiting, then reset mid-cycle
    r0_req = 1; r0_lock = 1; r0_addr = 6'd5;
    r1_req = 1; r1_addr = 6'd9;
    step();
    checks++;
    if (owner !== 2'b01 || r0_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL reset_prelock: owner=%b r0_rvalid=%b, required 01/1", owner, r0_rvalid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we} !== 5'b0 || owner !== 2'b00) begin
      errors++;
      $display("FAIL reset_async: gnt=%b%b rvalid=%b%b we=%b owner=%b, required all 0",
               r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we, owner);
    end
    do_reset();
  endtask

  task automatic test_tie();
    do_reset();
    r0_req = 1; r0_addr = 6'd5;
    r1_req = 1; r1_addr = 6'd9;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (r0_gnt !== (i % 2 == 0) || r1_gnt !== (i % 2 == 1) ||
          mem_addr !== ((i % 2 == 0) ? 6'd5 : 6'd9)) begin
        errors++;
        $display("FAIL tie_grant[%0d]: gnt0=%b gnt1=%b addr=%0d, required %0d/%0d addr %0d",
                 i, r0_gnt, r1_gnt, mem_addr, (i % 2 == 0), (i % 2 == 1), (i % 2 == 0) ? 5 : 9);
      end
      if (i > 0) begin
        checks++;
        if (i % 2 == 1) begin
          if (r0_rvalid !== 1'b1 || r1_rvalid !== 1'b0 || r0_rdata !== 16'h1005) begin
            errors++;
            $display("FAIL tie_rvalid[%0d]: rv0=%b rv1=%b rdata=%h, required 1/0/1005",
                     i, r0_rvalid, r1_rvalid, r0_rdata);
          end
        end else begin
          if (r1_rvalid !== 1'b1 || r0_rvalid !== 1'b0 || r1_rdata !== 16'h1009) begin
            errors++;
            $display("FAIL tie_rvalid[%0d]: rv0=%b rv1=%b rdata=%h, required 0/1/1009",
                     i, r0_rvalid, r1_rvalid, r1_rdata);
          end
        end
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_write_read();
    do_reset();
    r1_req = 1; r1_we = 1; r1_addr = 6'd3; r1_wdata = 16'hBEEF;
    @(negedge clk);
    checks++;
    if (r1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd3 || mem_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL wr_cmd: gnt1=%b we=%b addr=%0d data=%h, required 1/1/3/BEEF",
               r1_gnt, mem_we, mem_addr, mem_data);
    end
    step();
    r1_req = 0; r1_we = 0;
    r0_req = 1; r0_addr = 6'd3;
    @(negedge clk);
    checks++;
    if (r0_gnt !== 1'b1 || mem_we !== 1'b0 || r1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_cmd: gnt0=%b we=%b rv1=%b, required 1/0/0", r0_gnt, mem_we, r1_rvalid);
    end
    step();
    r0_req = 0;
    @(negedge clk);
    checks++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL wr_rd_data: rv0=%b rdata=%h, required 1/BEEF", r0_rvalid, r0_rdata);
    end
    step();
  endtask

  task automatic test_lock();
    logic [6:0] e_g0;
    logic [6:0] e_g1;
    logic [1:0] e_own [7];
    e_g0  = 7'b1000001;
    e_g1  = 7'b0011110;
    e_own = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      r0_req = 1; r0_addr = 6'd1;
      r1_req = (c >= 1 && c <= 4); r1_lock = r1_req; r1_addr = 6'd2;
      @(negedge clk);
      checks++;
      if (r0_gnt !== e_g0[c] || r1_gnt !== e_g1[c] || owner !== e_own[c]) begin
        errors++;
        $display("FAIL lock[%0d]: gnt0=%b gnt1=%b owner=%b, required %b/%b/%b",
                 c, r0_gnt, r1_gnt, owner, e_g0[c], e_g1[c], e_own[c]);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_hold_limit();
    logic [9:0] e_g1;
    logic [1:0] e_own [10];
    e_g1  = 10'b1000010000;
    e_own = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    do_reset();
    r0_req = 1; r0_lock = 1; r0_addr = 6'd2;
    r1_req = 1; r1_addr = 6'd7;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (d3_r0_gnt !== ~e_g1[c] || d3_r1_gnt !== e_g1[c] || d3_owner !== e_own[c]) begin
        errors++;
        $display("FAIL hold3[%0d]: gnt0=%b gnt1=%b owner=%b, required %b/%b/%b",
                 c, d3_r0_gnt, d3_r1_gnt, d3_owner, ~e_g1[c], e_g1[c], e_own[c]);
      end
      checks++;
      if (d0_r0_gnt !== 1'b1 || d0_r1_gnt !== 1'b0 || d0_owner !== ((c == 0) ? 2'b00 : 2'b01)) begin
        errors++;
        $display("FAIL hold0[%0d]: gnt0=%b gnt1=%b owner=%b, required 1/0/%b",
                 c, d0_r0_gnt, d0_r1_gnt, d0_owner, (c == 0) ? 2'b00 : 2'b01);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we} !== 5'b0 || mem_addr !== '0 ||
          mem_data !== '0 || {d3_r0_gnt, d3_r1_gnt, d3_mem_we, d0_r0_gnt, d0_r1_gnt, d0_mem_we} !== 6'b0 ||
          {d3_r0_rvalid, d3_r1_rvalid, d0_r0_rvalid, d0_r1_rvalid} !== 4'b0 ||
          d3_mem_addr !== '0 || d0_mem_addr !== '0 || d3_mem_data !== '0 || d0_mem_data !== '0) begin
        errors++;
        $display("FAIL idle[%0d]: gnt=%b%b rvalid=%b%b we=%b addr=%0h data=%h, required all 0",
                 c, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we, mem_addr, mem_data);
      end
      step();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_tie();
    test_write_read();
    test_lock();
    test_hold_limit();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
